mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Arbitrates one single-ported unified memory between the IF stage (instruction fetch) and MEM stage (lw/sw).
//  Owns the memory control pins, sequences each access over a fixed latency and returns data with a valid pulse.
//  Stalls the PC/IF side while a fetch waits.
//  Data wins ties; an anti-starvation counter guarantees fetch progress.
// PARAMETERS
//  ADDR_W      32  address width, both requesters and memory
//  DATA_W      32  data width
//  MEM_LAT     2   memory cycles per access, >=1; rdata sampled on last one
//  STARVE_MAX  4   consecutive data grants with ifReq pending before fetch is forced
// PORTS
//  clk       in   1       rising-edge clock, the only clock
//  rst       in   1       reset, synchronous, active-high
//  ifReq     in   1       fetch request; held high until ifGnt
//  ifAddr    in   ADDR_W  fetch byte address (pc)
//  ifGnt     out  1       1-cycle pulse: fetch request accepted and latched
//  ifRdata   out  DATA_W  fetched instruction; valid when ifValid
//  ifValid   out  1       1-cycle pulse: ifRdata updated
//  dReq      in   1       data request; held until dGnt
//  dWe       in   1       1=store, 0=load
//  dAddr     in   ADDR_W  data byte address
//  dWdata    in   DATA_W  store data
//  dGnt      out  1       1-cycle pulse: data request accepted
//  dRdata    out  DATA_W  load data; valid when dValid
//  dValid    out  1       1-cycle pulse: data access completed (load and store)
//  memEn     out  1       memory enable, high for whole access
//  memWe     out  1       memory write enable, qualified by memEn
//  memAddr   out  ADDR_W  latched access address
//  memWdata  out  DATA_W  latched store data
//  memRdata  in   DATA_W  memory read data
//  pcStall   out  1       combinational: ifReq & ~ifGnt (hold PC and IF/ID)
// BEHAVIOUR
//  - All outputs registered except pcStall.
//  - Reset: all outputs 0, state=IDLE, cnt=0, streak=0. Any in-flight access is dropped; no valid pulse.
//  - FSM states:
//    - IDLE: if no request, stay. Else pick owner:
//      - fetch if ~dReq, or if streak==STARVE_MAX;
//      - otherwise data.
//      - Latch addr/we/wdata (we=0 for fetch), cnt<=MEM_LAT-1, go BUSY.
//    - BUSY: memEn=1, memWe=latched we. Gnt pulse for the owner in the first BUSY cycle only.
//      - cnt>0: cnt<=cnt-1.
//      - cnt==0: capture memRdata into owner rdata (loads/fetch only; stores leave dRdata unchanged).
//        Owner valid pulses next cycle. Go IDLE.
//  - Throughput: one access per MEM_LAT+1 cycles.
//  - Latency: request seen in IDLE at edge T -> gnt at T+1, valid at T+MEM_LAT+1.
//  - streak updates on each IDLE grant:
//    - data grant while ifReq=1: +1, saturating at STARVE_MAX;
//    - fetch grant, or ifReq=0: reset to 0.
//  - Requests arriving during BUSY wait; req still high on the valid cycle is a new request.
//  - memEn/memWe drop to 0 in IDLE. memAddr/memWdata hold last value.
//  - rdata outputs hold until the next capture for that requester.
// TESTING
//  1. Reset, ifReq=1 ifAddr=0x64, memRdata=0x8C220000, MEM_LAT=2
//     -> ifGnt at cycle 1; ifValid at cycle 3 with ifRdata=0x8C220000; pcStall high only in cycle 0.
//  2. ifReq and dReq (load, dAddr=0x4) rise together -> dGnt first; ifGnt 3 cycles later; memAddr switches 0x4 -> ifAddr.
//  3. dReq held high (stores) with ifReq=1
//     -> exactly 4 dGnt, then ifGnt; streak back to 0; dRdata unchanged by stores.
//  4. rst asserted mid-BUSY (cnt=1)
//     -> next cycle all outputs 0, no valid pulse; a fresh request after reset completes normally.
//  5. MEM_LAT=1, back-to-back fetches
//     -> ifValid every 2 cycles, memEn duty 1 of 2, addresses 0x64, 0x68 in order.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of IF-stage, MEM-stage and memory-side signals around the
// unified memory port arbiter. The arbiter takes the slave view; the
// surrounding pipeline/memory model takes the master view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // fetch side
  logic              ifReq;
  logic [ADDR_W-1:0] ifAddr;
  logic              ifGnt;
  logic [DATA_W-1:0] ifRdata;
  logic              ifValid;
  // data side
  logic              dReq;
  logic              dWe;
  logic [ADDR_W-1:0] dAddr;
  logic [DATA_W-1:0] dWdata;
  logic              dGnt;
  logic [DATA_W-1:0] dRdata;
  logic              dValid;
  // memory pins
  logic              memEn;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWdata;
  logic [DATA_W-1:0] memRdata;
  // PC hold
  logic              pcStall;

  modport slave (
    input  ifReq, ifAddr, dReq, dWe, dAddr, dWdata, memRdata,
    output ifGnt, ifRdata, ifValid, dGnt, dRdata, dValid,
           memEn, memWe, memAddr, memWdata, pcStall
  );

  modport master (
    output ifReq, ifAddr, dReq, dWe, dAddr, dWdata, memRdata,
    input  ifGnt, ifRdata, ifValid, dGnt, dRdata, dValid,
           memEn, memWe, memAddr, memWdata, pcStall
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// Data wins ties; after STARVE_MAX consecutive data grants with a fetch
// waiting, the fetch is forced through. Each access holds the memory for
// MEM_LAT cycles, then returns to IDLE for one cycle where the result is
// flagged valid and the next request can be picked.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int STK_W = $clog2(STARVE_MAX + 1);
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STK_W-1:0]  streak_q, streak_d;
  logic              owner_q, owner_d;
  logic              memEn_q, memEn_d;
  logic              memWe_q, memWe_d;
  logic [ADDR_W-1:0] memAddr_q, memAddr_d;
  logic [DATA_W-1:0] memWdata_q, memWdata_d;
  logic              ifGnt_q, ifGnt_d;
  logic              dGnt_q, dGnt_d;
  logic              ifValid_q, ifValid_d;
  logic              dValid_q, dValid_d;
  logic [DATA_W-1:0] ifRdata_q, ifRdata_d;
  logic [DATA_W-1:0] dRdata_q, dRdata_d;
  logic              pick_fetch;

  // Next-state: arbitration in IDLE, latency countdown and capture in BUSY
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    streak_d   = streak_q;
    owner_d    = owner_q;
    memEn_d    = memEn_q;
    memWe_d    = memWe_q;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;
    ifRdata_d  = ifRdata_q;
    dRdata_d   = dRdata_q;
    ifGnt_d    = 1'b0;
    dGnt_d     = 1'b0;
    ifValid_d  = 1'b0;
    dValid_d   = 1'b0;
    pick_fetch = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.ifReq || bus.dReq) begin
          // fetch only wins when data is absent or fetch has been starved
          pick_fetch = !bus.dReq || (streak_q == STK_W'(STARVE_MAX));
          state_d    = BUSY;
          cnt_d      = CNT_W'(MEM_LAT - 1);
          memEn_d    = 1'b1;
          if (pick_fetch) begin
            owner_d   = OWN_IF;
            memWe_d   = 1'b0;
            memAddr_d = bus.ifAddr;
            ifGnt_d   = 1'b1;
            streak_d  = '0;
          end else begin
            owner_d    = OWN_D;
            memWe_d    = bus.dWe;
            memAddr_d  = bus.dAddr;
            memWdata_d = bus.dWdata;
            dGnt_d     = 1'b1;
            if (!bus.ifReq)
              streak_d = '0;
            else if (streak_q != STK_W'(STARVE_MAX))
              streak_d = streak_q + STK_W'(1);
          end
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          // last memory cycle: rdata is valid now, release the port
          state_d = IDLE;
          memEn_d = 1'b0;
          memWe_d = 1'b0;
          if (owner_q == OWN_IF) begin
            ifRdata_d = bus.memRdata;
            ifValid_d = 1'b1;
          end else begin
            if (!memWe_q) dRdata_d = bus.memRdata;
            dValid_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, synchronous reset drops any access in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      streak_q   <= '0;
      owner_q    <= OWN_IF;
      memEn_q    <= 1'b0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      ifGnt_q    <= 1'b0;
      dGnt_q     <= 1'b0;
      ifValid_q  <= 1'b0;
      dValid_q   <= 1'b0;
      ifRdata_q  <= '0;
      dRdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      streak_q   <= streak_d;
      owner_q    <= owner_d;
      memEn_q    <= memEn_d;
      memWe_q    <= memWe_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
      ifGnt_q    <= ifGnt_d;
      dGnt_q     <= dGnt_d;
      ifValid_q  <= ifValid_d;
      dValid_q   <= dValid_d;
      ifRdata_q  <= ifRdata_d;
      dRdata_q   <= dRdata_d;
    end
  end

  assign bus.ifGnt    = ifGnt_q;
  assign bus.dGnt     = dGnt_q;
  assign bus.ifValid  = ifValid_q;
  assign bus.dValid   = dValid_q;
  assign bus.ifRdata  = ifRdata_q;
  assign bus.dRdata   = dRdata_q;
  assign bus.memEn    = memEn_q;
  assign bus.memWe    = memWe_q;
  assign bus.memAddr  = memAddr_q;
  assign bus.memWdata = memWdata_q;
  // hold PC/IF while a fetch is pending and not yet accepted
  assign bus.pcStall  = bus.ifReq & ~ifGnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed cycle table, multi-cycle corner
// sequences (starvation, reset mid-access, MEM_LAT=1 streaming) and a
// randomized run against a transaction-schedule reference model.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SM = 4;
  localparam int L  = 2;

  logic clk = 1'b0;
  logic rst1, rst2;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b2 ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(L), .STARVE_MAX(SM))
    dut1 (.clk(clk), .rst(rst1), .bus(b1));
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .STARVE_MAX(SM))
    dut2 (.clk(clk), .rst(rst2), .bus(b2));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk1(input string t, input logic eig, input logic eiv,
                      input logic [31:0] eird, input logic edg, input logic edv,
                      input logic [31:0] edrd, input logic een, input logic ewe,
                      input logic [31:0] ea, input logic epc);
    chkb({t, ".ifGnt"},   b1.ifGnt,   eig);
    chkb({t, ".ifValid"}, b1.ifValid, eiv);
    chk ({t, ".ifRdata"}, b1.ifRdata, eird);
    chkb({t, ".dGnt"},    b1.dGnt,    edg);
    chkb({t, ".dValid"},  b1.dValid,  edv);
    chk ({t, ".dRdata"},  b1.dRdata,  edrd);
    chkb({t, ".memEn"},   b1.memEn,   een);
    chkb({t, ".memWe"},   b1.memWe,   ewe);
    chk ({t, ".memAddr"}, b1.memAddr, ea);
    chkb({t, ".pcStall"}, b1.pcStall, epc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv1(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                      input logic [31:0] da, input logic [31:0] dwd, input logic [31:0] mr);
    b1.ifReq = ir; b1.ifAddr = ia; b1.dReq = dr; b1.dWe = dw;
    b1.dAddr = da; b1.dWdata = dwd; b1.memRdata = mr;
  endtask

  typedef struct {
    logic rst, ir; logic [31:0] ia; logic dr, dw; logic [31:0] da, dwd, mr;
    logic eig, eiv; logic [31:0] eird; logic edg, edv; logic [31:0] edrd;
    logic een, ewe; logic [31:0] ea; logic epc;
  } vec_t;

  function automatic vec_t v(input logic rst, input logic ir, input logic [31:0] ia,
      input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dwd,
      input logic [31:0] mr, input logic eig, input logic eiv, input logic [31:0] eird,
      input logic edg, input logic edv, input logic [31:0] edrd, input logic een,
      input logic ewe, input logic [31:0] ea, input logic epc);
    vec_t r;
    r.rst = rst; r.ir = ir; r.ia = ia; r.dr = dr; r.dw = dw; r.da = da; r.dwd = dwd;
    r.mr = mr; r.eig = eig; r.eiv = eiv; r.eird = eird; r.edg = edg; r.edv = edv;
    r.edrd = edrd; r.een = een; r.ewe = ewe; r.ea = ea; r.epc = epc;
    return r;
  endfunction

  vec_t tv[13];

  initial begin
    // reference model state for the random phase
    bit          m_act, m_own, m_we;
    int          m_s, m_stk;
    logic [31:0] m_addr, m_wd, m_ird, m_drd;
    bit          ir, dr, dwe, p_ig, p_dg;
    logic [31:0] ia, da, dwd, mr;
    bit          e_ig, e_dg, e_en, e_iv, e_dv;
    int          ndg, lat;
    bit          got_if, got, seen, ag;
    logic [31:0] addrs[$];

    //           rst ir ia       dr dw da dwd mr         | ig iv ird          dg dv drd          en we addr     pc
    tv[0]  = v(1, 0, 32'h0,   0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,   0);
    tv[1]  = v(0, 1, 32'h64,  0, 0, 0, 0, 32'h8C220000, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,   1);
    tv[2]  = v(0, 1, 32'h64,  0, 0, 0, 0, 32'h8C220000, 1, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h64,  0);
    tv[3]  = v(0, 0, 32'h64,  0, 0, 0, 0, 32'h8C220000, 0, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h64,  0);
    tv[4]  = v(0, 0, 32'h64,  0, 0, 0, 0, 32'h8C220000, 0, 1, 32'h8C220000, 0, 0, 32'h0,        0, 0, 32'h64,  0);
    tv[5]  = v(0, 0, 32'h64,  0, 0, 0, 0, 32'h8C220000, 0, 0, 32'h8C220000, 0, 0, 32'h0,        0, 0, 32'h64,  0);
    tv[6]  = v(0, 1, 32'h100, 1, 0, 4, 0, 32'h11111111, 0, 0, 32'h8C220000, 0, 0, 32'h0,        0, 0, 32'h64,  1);
    tv[7]  = v(0, 1, 32'h100, 1, 0, 4, 0, 32'h11111111, 0, 0, 32'h8C220000, 1, 0, 32'h0,        1, 0, 32'h4,   1);
    tv[8]  = v(0, 1, 32'h100, 0, 0, 4, 0, 32'h11111111, 0, 0, 32'h8C220000, 0, 0, 32'h0,        1, 0, 32'h4,   1);
    tv[9]  = v(0, 1, 32'h100, 0, 0, 4, 0, 32'h11111111, 0, 0, 32'h8C220000, 0, 1, 32'h11111111, 0, 0, 32'h4,   1);
    tv[10] = v(0, 1, 32'h100, 0, 0, 4, 0, 32'h22222222, 1, 0, 32'h8C220000, 0, 0, 32'h11111111, 1, 0, 32'h100, 0);
    tv[11] = v(0, 0, 32'h100, 0, 0, 4, 0, 32'h22222222, 0, 0, 32'h8C220000, 0, 0, 32'h11111111, 1, 0, 32'h100, 0);
    tv[12] = v(0, 0, 32'h100, 0, 0, 4, 0, 32'h22222222, 0, 1, 32'h22222222, 0, 0, 32'h11111111, 0, 0, 32'h100, 0);

    rst1 = 1'b1; rst2 = 1'b1;
    drv1(0, 0, 0, 0, 0, 0, 0);
    b2.ifReq = 0; b2.ifAddr = 0; b2.dReq = 0; b2.dWe = 0;
    b2.dAddr = 0; b2.dWdata = 0; b2.memRdata = 0;
    tick();

    // directed table: single fetch, then simultaneous load+fetch
    for (int i = 0; i < 13; i++) begin
      rst1 = tv[i].rst;
      drv1(tv[i].ir, tv[i].ia, tv[i].dr, tv[i].dw, tv[i].da, tv[i].dwd, tv[i].mr);
      @(negedge clk);
      if (!tv[i].rst)
        chk1($sformatf("vec%0d", i), tv[i].eig, tv[i].eiv, tv[i].eird, tv[i].edg,
             tv[i].edv, tv[i].edrd, tv[i].een, tv[i].ewe, tv[i].ea, tv[i].epc);
      tick();
    end

    // starvation: stores back to back with a fetch waiting
    drv1(1, 32'h200, 1, 1, 32'h300, 32'hA0, 0);
    ndg = 0; got_if = 0;
    for (int k = 0; k < 60 && !got_if; k++) begin
      b1.memRdata = $urandom;
      @(negedge clk);
      got = b1.dGnt;
      if (b1.dGnt) ndg++;
      if (b1.ifGnt) got_if = 1;
      tick();
      if (got) begin b1.dWdata = b1.dWdata + 1; b1.dAddr = b1.dAddr + 4; end
    end
    @(negedge clk);
    chkb("starve.ifGnt_seen", got_if, 1'b1);
    chk("starve.dGnt_count", ndg, 32'd4);
    chk("starve.dRdata_kept", b1.dRdata, 32'h11111111);
    tick();
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (b1.dGnt || b1.ifGnt) begin
        got = 1;
        chkb("starve.streak_reset_data_wins", b1.dGnt, 1'b1);
      end
      tick();
    end
    chkb("starve.next_grant_seen", got, 1'b1);
    drv1(0, 0, 0, 0, 0, 0, 0);
    repeat (5) tick();

    // reset in the first BUSY cycle (cnt=1)
    drv1(1, 32'h400, 0, 0, 0, 0, 32'h55555555);
    seen = 0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clk);
      if (b1.ifGnt) begin
        seen = 1;
        chkb("rst.busy_memEn", b1.memEn, 1'b1);
        rst1 = 1'b1;
        b1.ifReq = 1'b0;
      end
      tick();
    end
    chkb("rst.gnt_seen", seen, 1'b1);
    @(negedge clk);
    chk1("rst.zero", 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0, 0);
    chk("rst.memWdata", b1.memWdata, 32'h0);
    rst1 = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chkb($sformatf("rst.no_valid%0d", k), b1.ifValid, 1'b0);
      chkb($sformatf("rst.no_memEn%0d", k), b1.memEn, 1'b0);
      tick();
    end
    drv1(1, 32'h404, 0, 0, 0, 0, 32'h66666666);
    lat = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (b1.ifGnt) b1.ifReq = 1'b0;
      if (b1.ifValid && lat < 0) begin
        lat = k;
        chk("rst.fresh_rdata", b1.ifRdata, 32'h66666666);
      end
      tick();
    end
    chk("rst.fresh_latency", lat, 32'd3);

    // MEM_LAT=1 back-to-back fetches on the second instance
    rst2 = 1'b0;
    b2.ifReq = 1'b1; b2.ifAddr = 32'h64;
    ag = 0;
    for (int k = 0; k < 10; k++) begin
      if (ag) b2.ifAddr = b2.ifAddr + 4;
      ag = 0;
      b2.memRdata = 32'h1000 + k;
      @(negedge clk);
      chkb($sformatf("lat1.memEn%0d", k), b2.memEn, k % 2 == 1);
      chkb($sformatf("lat1.ifValid%0d", k), b2.ifValid, (k >= 2) && (k % 2 == 0));
      if (k == 2) chk("lat1.ifRdata", b2.ifRdata, 32'h1001);
      if (b2.ifGnt) begin addrs.push_back(b2.memAddr); ag = 1; end
      tick();
    end
    chk("lat1.grants", addrs.size(), 32'd5);
    if (addrs.size() >= 2) begin
      chk("lat1.addr0", addrs[0], 32'h64);
      chk("lat1.addr1", addrs[1], 32'h68);
    end
    b2.ifReq = 1'b0;

    // randomized run against the schedule model
    rst1 = 1'b1;
    drv1(0, 0, 0, 0, 0, 0, 0);
    tick();
    rst1 = 1'b0;
    m_act = 0; m_own = 0; m_we = 0; m_s = 0; m_stk = 0;
    m_addr = 0; m_wd = 0; m_ird = 0; m_drd = 0;
    ir = 0; dr = 0; dwe = 0; ia = 0; da = 0; dwd = 0; p_ig = 0; p_dg = 0;
    for (int c = 0; c < 400; c++) begin
      if (!ir || p_ig) begin ir = ($urandom_range(2) != 0); ia = $urandom & 32'hFFFF_FFFC; end
      if (!dr || p_dg) begin
        dr = ($urandom_range(3) != 0); dwe = $urandom_range(1) != 0;
        da = $urandom & 32'hFFFF_FFFC; dwd = $urandom;
      end
      mr = $urandom;
      drv1(ir, ia, dr, dwe, da, dwd, mr);
      @(negedge clk);
      e_ig = m_act && c == m_s && !m_own;
      e_dg = m_act && c == m_s && m_own;
      e_en = m_act && c >= m_s && c < m_s + L;
      e_iv = m_act && c == m_s + L && !m_own;
      e_dv = m_act && c == m_s + L && m_own;
      chk1($sformatf("rand%0d", c), e_ig, e_iv, m_ird, e_dg, e_dv, m_drd, e_en,
           e_en && m_we, m_addr, ir && !e_ig);
      chk($sformatf("rand%0d.memWdata", c), b1.memWdata, m_wd);
      p_ig = e_ig; p_dg = e_dg;
      // what the clock edge at the end of cycle c does
      if (m_act && c == m_s + L - 1 && !m_we) begin
        if (m_own) m_drd = mr; else m_ird = mr;
      end
      if ((!m_act || c >= m_s + L) && (ir || dr)) begin
        if (!dr || m_stk == SM) begin
          m_own = 0; m_we = 0; m_addr = ia; m_stk = 0;
        end else begin
          m_own = 1; m_we = dwe; m_addr = da; m_wd = dwd;
          m_stk = ir ? ((m_stk + 1 > SM) ? SM : m_stk + 1) : 0;
        end
        m_act = 1; m_s = c + 1;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
